// File: rtl/ecc_scrub_data_memory.sv
// SEC Hamming-protected data memory with a background scrubber.
// Each 32-bit word is stored as a 38-bit codeword. The CPU read path corrects
// single-bit errors combinationally; the scrubber repairs them in the array.
module ecc_scrub_data_memory #(
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned AW             = 10,
    parameter int unsigned SCRUB_INTERVAL = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WE,
    input  logic [31:0]   A,
    input  logic [31:0]   WD,
    output logic [31:0]   RD,
    output logic          rd_corrected,
    input  logic          inject_en,
    input  logic [5:0]    inject_bit,
    output logic          scrub_corr,
    output logic          uncorr_err,
    output logic [15:0]   err_count,
    output logic [AW-1:0] scrub_addr
);

    localparam int unsigned CW_W  = 38;
    localparam int unsigned CNT_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [5:0]  MAX_POS = 6'd38;

    typedef enum logic [1:0] {S_WAIT, S_CHECK, S_FIX} state_t;

    // Syndrome: XOR of the 1-based positions of all set bits.
    function automatic logic [5:0] syndrome(input logic [CW_W-1:0] cw);
        logic [5:0] s;
        s = '0;
        for (int k = 0; k < 38; k++) begin
            if (cw[k]) s = s ^ 6'(k + 1);
        end
        return s;
    endfunction

    // Data bits fill non-power-of-two positions; check bits cancel the syndrome.
    function automatic logic [CW_W-1:0] encode(input logic [31:0] d);
        logic [CW_W-1:0] cw;
        logic [5:0]      s;
        logic [4:0]      j;
        cw = '0;
        j  = '0;
        for (int k = 0; k < 38; k++) begin
            if (((k + 1) & k) != 0) begin
                cw[k] = d[j];
                j     = j + 5'd1;
            end
        end
        s = syndrome(cw);
        for (int p = 0; p < 6; p++) begin
            cw[(1 << p) - 1] = s[p];
        end
        return cw;
    endfunction

    // Pull the 32 data bits back out of a codeword.
    function automatic logic [31:0] extract(input logic [CW_W-1:0] cw);
        logic [31:0] d;
        logic [4:0]  j;
        d = '0;
        j = '0;
        for (int k = 0; k < 38; k++) begin
            if (((k + 1) & k) != 0) begin
                d[j] = cw[k];
                j    = j + 5'd1;
            end
        end
        return d;
    endfunction

    // Flip the position named by the syndrome when it lies inside the codeword.
    function automatic logic [CW_W-1:0] correct(input logic [CW_W-1:0] cw, input logic [5:0] s);
        logic [CW_W-1:0] c;
        c = cw;
        if (s != 6'd0 && s <= MAX_POS) c[s - 6'd1] = ~c[s - 6'd1];
        return c;
    endfunction

    logic [CW_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    a_idx;
    logic             unused_a_hi;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    scrub_addr_q, scrub_addr_d;
    logic             scrub_corr_q, scrub_corr_d;
    logic             uncorr_err_q, uncorr_err_d;
    logic [15:0]      err_count_q, err_count_d;

    logic [CW_W-1:0]  rd_cw, sc_cw, sc_fixed;
    logic [5:0]       rd_syn, sc_syn;
    logic             scrub_we;
    logic             mem_wr_en;
    logic [AW-1:0]    mem_wr_idx;
    logic [CW_W-1:0]  mem_wr_cw;

    assign a_idx       = A[AW-1:0];
    assign unused_a_hi = ^A[31:AW];

    // CPU read port and scrubber read port decode.
    always_comb begin
        rd_cw        = mem_q[a_idx];
        rd_syn       = syndrome(rd_cw);
        RD           = extract(correct(rd_cw, rd_syn));
        rd_corrected = (rd_syn != 6'd0) && (rd_syn <= MAX_POS);
        sc_cw        = mem_q[scrub_addr_q];
        sc_syn       = syndrome(sc_cw);
        sc_fixed     = correct(sc_cw, sc_syn);
    end

    // Scrubber next-state: wait interval, check a word, optionally repair it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scrub_addr_d = scrub_addr_q;
        scrub_corr_d = 1'b0;
        uncorr_err_d = uncorr_err_q;
        err_count_d  = err_count_q;
        scrub_we     = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_CHECK: begin
                if (sc_syn != 6'd0 && sc_syn <= MAX_POS) begin
                    state_d = S_FIX;
                end else begin
                    if (sc_syn != 6'd0) uncorr_err_d = 1'b1;
                    scrub_addr_d = scrub_addr_q + AW'(1);
                    cnt_d        = CNT_W'(SCRUB_INTERVAL - 1);
                    state_d      = S_WAIT;
                end
            end
            S_FIX: begin
                // A CPU write to the array this cycle takes the port; skip the repair.
                if (!WE) begin
                    scrub_we     = 1'b1;
                    scrub_corr_d = 1'b1;
                    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                end
                scrub_addr_d = scrub_addr_q + AW'(1);
                cnt_d        = CNT_W'(SCRUB_INTERVAL - 1);
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Array write arbitration: CPU write, then scrub repair, then fault injection.
    always_comb begin
        mem_wr_en  = 1'b0;
        mem_wr_idx = a_idx;
        mem_wr_cw  = encode(WD);
        if (WE) begin
            mem_wr_en = 1'b1;
        end else if (scrub_we) begin
            mem_wr_en  = 1'b1;
            mem_wr_idx = scrub_addr_q;
            mem_wr_cw  = encode(extract(sc_fixed));
        end else if (inject_en && inject_bit < MAX_POS) begin
            mem_wr_en = 1'b1;
            mem_wr_cw = mem_q[a_idx] ^ (38'd1 << inject_bit);
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem_q[mem_wr_idx] <= mem_wr_cw;
    end

    // Scrubber state and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            cnt_q        <= CNT_W'(SCRUB_INTERVAL - 1);
            scrub_addr_q <= '0;
            scrub_corr_q <= 1'b0;
            uncorr_err_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scrub_addr_q <= scrub_addr_d;
            scrub_corr_q <= scrub_corr_d;
            uncorr_err_q <= uncorr_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign scrub_corr = scrub_corr_q;
    assign uncorr_err = uncorr_err_q;
    assign err_count  = err_count_q;
    assign scrub_addr = scrub_addr_q;

endmodule

// File: doc/ecc_scrub_data_memory.md
# ecc_scrub_data_memory

Hamming-protected data memory that replaces the plain data memory directly downstream of the TMR voter. It consumes the voted `MemWrite`/`ALUResult`/`RD2_Top` and returns corrected read data to all three cores. Each word is stored as a 38-bit SEC codeword. A background scrubber FSM walks the array, rewrites corrected codewords, and reports error statistics.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words.
- `AW`, 10: word-index width; `2**AW == DEPTH`.
- `SCRUB_INTERVAL`, 256: idle cycles between scrub visits (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `WE`  in  1  voted memory write enable.
- `A`  in  32  voted address; word index = `A[AW-1:0]`, upper bits ignored.
- `WD`  in  32  voted write data (raw; encoded internally).
- `RD`  out  32  corrected read data of `mem[A]`, combinational.
- `rd_corrected`  out  1  combinational; the `RD` path corrected a single-bit error this cycle.
- `inject_en`  in  1  fault injection: flip one stored bit of `mem[A]`.
- `inject_bit`  in  6  codeword bit to flip (0..37); values 38..63 are ignored.
- `scrub_corr`  out  1  registered, one-cycle pulse: scrubber repaired a word.
- `uncorr_err`  out  1  sticky: scrubber saw an uncorrectable syndrome.
- `err_count`  out  16  scrubber repairs, saturating at 16'hFFFF.
- `scrub_addr`  out  AW  word index the scrubber will visit next.

## Operation
- Codeword layout (1-indexed positions 1..38): check bits at positions 1, 2, 4, 8, 16, 32. Data bits `D[0]..D[31]` fill the remaining positions in ascending order. Codeword bit `k` is position `k+1`. Check bit `p` is the even parity over all positions whose index has bit `log2 p` set.
- Decode: syndrome S = XOR of the indices of all set positions.
  - S==0: clean.
  - 1≤S≤38: flip position S.
  - S>38: uncorrectable; data returned uncorrected.
- Write: on posedge with `WE`=1, `mem[A] <= enc(WD)`.
- Read: `RD = dec(mem[A])`, purely combinational. The read path never writes back.
- Injection: on posedge with `inject_en`=1, `WE`=0 and `inject_bit`<38, `mem[A]` is XORed with `1<<inject_bit`. If `WE`=1 in the same cycle, the write wins and the injection is dropped.
- Scrubber FSM:
  - WAIT: counter runs `SCRUB_INTERVAL-1`→0; at 0, go to CHECK.
  - CHECK: decode `mem[scrub_addr]` on a dedicated read port.
    - Clean: advance `scrub_addr`, go to WAIT.
    - Correctable: go to FIX.
    - Uncorrectable: set `uncorr_err`, advance, go to WAIT.
  - FIX: write `enc(corrected data)` to `scrub_addr`, pulse `scrub_corr`, increment `err_count` (saturating), advance, go to WAIT.
  - CPU priority: if `WE`=1 in a FIX cycle, the scrub write is cancelled. There is no pulse and no count; the FSM still advances (the word was just rewritten or will be revisited). An `inject_en` in a FIX cycle is also dropped.
  - `scrub_addr` wraps from DEPTH-1 to 0.
- Memory array contents are not reset.

## Timing
- Reset values: FSM=WAIT, interval counter=`SCRUB_INTERVAL-1`, `scrub_addr`=0, `scrub_corr`=0, `uncorr_err`=0, `err_count`=0.
- Reset is asynchronous; asserting it mid-FIX aborts the write-back.
- Write latency: data is visible on `RD` in the cycle after the write edge.
- Read latency: 0 cycles, combinational from `A` and array state.
- Scrub period: one visit every `SCRUB_INTERVAL+1` cycles for a clean word and `SCRUB_INTERVAL+2` for a repaired word. After reset, the first CHECK is in cycle `SCRUB_INTERVAL`.
- `scrub_corr` is high for exactly the cycle after the FIX edge.
- `err_count` updates on the same edge that raises `scrub_corr`.

## Test plan
- **Encode/decode:** write 32'hDEADBEEF at word 5 → `RD`=DEADBEEF, `rd_corrected`=0; write 0 → stored codeword is all-zero.
- **Single-bit correction on read:** for each `inject_bit` 0..37 on word 5 holding 32'h12345678 → `RD`=12345678 and `rd_corrected`=1 every time.
- **Scrub repair:** `SCRUB_INTERVAL`=4; inject bit 17 at word 0 → `scrub_corr` pulses once; `err_count`=1; stored codeword is clean afterward (`rd_corrected`=0).
- **Uncorrectable:** flip bits 36 and 37 of word 0 (syndrome 37 XOR 38 = 3, which is correctable, so miscorrects silently). Then flip bits such that S>38, e.g. bits 31 and 37 (S=32 XOR 38=6)... use bits 32 and 37 (positions 33, 38; S=7): choose a pattern whose S is 39..63 → `uncorr_err`=1 and stays set until `rst`.
- **Conflict:** make `WE`=1 coincide with FIX → no `scrub_corr`, `err_count` unchanged, new data stored, `scrub_addr` advances.
- **Wrap and saturation:** `DEPTH`=4; verify `scrub_addr` sequence 0,1,2,3,0. Force 65536 repairs → `err_count` holds at FFFF. Assert `rst` mid-sequence → all outputs return to their reset values immediately.
